// File: rtl/clic_pkg.sv
// -----------------------------------------------------------------------------
// clic_pkg
// Shared CLIC definitions. The gateway imports this package so that trigger
// polarity is named consistently with the rest of the CLIC codebase.
//   clic_trig_e : decoding of attr_trig[0] (0 = level, 1 = edge)
// -----------------------------------------------------------------------------
package clic_pkg;

    typedef enum logic {
        TRIG_LEVEL = 1'b0,
        TRIG_EDGE  = 1'b1
    } clic_trig_e;

endpackage : clic_pkg

// File: rtl/clic_gateway_cell.sv
// -----------------------------------------------------------------------------
// clic_gateway_cell
// Pending-bit logic for a single interrupt source.
// Holds the optional two-flop synchronizer, the previous-sample flop used for
// rising-edge detection, and the registered pending bit.
// Optional feature macro: CLIC_GATEWAY_SYNC_EN (adds the 2-flop synchronizer).
// Ports:
//   clk_i    : clock
//   rst_ni   : asynchronous reset, active low
//   s        : raw interrupt line for this source
//   le       : trigger select, 1 = edge, 0 = level
//   qe       : one-cycle software write strobe to the pending bit
//   wdata    : software write value (valid with qe)
//   ack_hit  : core acknowledged this source this cycle
//   ip       : registered pending bit
// -----------------------------------------------------------------------------
module clic_gateway_cell
    import clic_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic s,
    input  logic le,
    input  logic qe,
    input  logic wdata,
    input  logic ack_hit,
    output logic ip
);

    logic samp_s;
    logic prev_r;
    logic rise_s;
    logic ip_r;
    logic ip_next_s;

`ifdef CLIC_GATEWAY_SYNC_EN
    logic sync1_r;
    logic sync2_r;

    // Two-flop synchronizer for a possibly asynchronous source line
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= s;
            sync2_r <= sync1_r;
        end
    end

    assign samp_s = sync2_r;
`else
    assign samp_s = s;
`endif

    assign rise_s = samp_s & ~prev_r;

    // Previous-sample register for rising-edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= samp_s;
        end
    end

    // Next pending value: a new edge outranks software writes, which outrank ack
    always_comb begin
        ip_next_s = ip_r;
        if (le == TRIG_LEVEL) begin
            ip_next_s = samp_s;
        end else if (rise_s) begin
            ip_next_s = 1'b1;
        end else if (qe) begin
            ip_next_s = wdata;
        end else if (ack_hit) begin
            ip_next_s = 1'b0;
        end else begin
            ip_next_s = ip_r;
        end
    end

    // Pending flop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ip_r <= 1'b0;
        end else begin
            ip_r <= ip_next_s;
        end
    end

    assign ip = ip_r;

endmodule : clic_gateway_cell

// File: rtl/clic_gateway.sv
// -----------------------------------------------------------------------------
// clic_gateway
// Per-source interrupt gateway feeding the CLIC register adapter's ip_i.
// Level sources: pending follows the source with one cycle of latency.
// Edge sources: pending sets on a rising edge and clears on core acknowledge
// or a software write of 0; software writes to clicint.ip are merged here.
// Optional feature macro: CLIC_GATEWAY_SYNC_EN (2-flop synchronizer per
// source, source-to-ip_o latency becomes 3 cycles).
// Ports:
//   clk_i      : clock
//   rst_ni     : asynchronous reset, active low
//   intr_src_i : raw interrupt lines, active high
//   le_i       : trigger select per source, 1 = edge, 0 = level
//   ip_sw_qe_i : software write strobe to clicint.ip
//   ip_sw_i    : software write data
//   ack_i      : core accepted an interrupt this cycle
//   ack_id_i   : id of the accepted interrupt
//   ip_o       : registered pending vector
// -----------------------------------------------------------------------------
module clic_gateway
    import clic_pkg::*;
#(
    parameter  int N_SOURCE = 32,
    localparam int SrcW     = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SOURCE-1:0] intr_src_i,
    input  logic [N_SOURCE-1:0] le_i,
    input  logic [N_SOURCE-1:0] ip_sw_qe_i,
    input  logic [N_SOURCE-1:0] ip_sw_i,
    input  logic                ack_i,
    input  logic [SrcW-1:0]     ack_id_i,
    output logic [N_SOURCE-1:0] ip_o
);

    logic [N_SOURCE-1:0] ack_hit_s;

    // Ids at or above N_SOURCE never match any cell, so such acks are dropped.
    for (genvar i = 0; i < N_SOURCE; i++) begin : g_cell
        assign ack_hit_s[i] = ack_i & (ack_id_i == SrcW'(i));

        clic_gateway_cell u_cell (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .s       (intr_src_i[i]),
            .le      (le_i[i]),
            .qe      (ip_sw_qe_i[i]),
            .wdata   (ip_sw_i[i]),
            .ack_hit (ack_hit_s[i]),
            .ip      (ip_o[i])
        );
    end

endmodule : clic_gateway
